// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter: NUM_REQ valid/ready producers share one sync FIFO write port.
// A winner may keep the port for up to MAX_BURST consecutive beats before the grant rotates.
// Optional statistics counters are built when FIFO_ARB_STATS_EN is defined.

module fifo_wr_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned MAX_BURST  = 4,
    localparam int unsigned IDW       = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_full,
    output logic                          fifo_wr_en,
    output logic [DATA_WIDTH-1:0]         fifo_din,
    output logic [IDW-1:0]                grant_id,
    output logic                          busy
`ifdef FIFO_ARB_STATS_EN
    ,
    output logic [NUM_REQ*16-1:0]         beat_cnt_vec,
    output logic [15:0]                   stall_cnt
`endif
);

    localparam int unsigned BCW = $clog2(MAX_BURST + 1);
    // beat_cnt value on the beat that completes a burst
    localparam logic [BCW-1:0] LastBeat = BCW'(MAX_BURST - 1);

    typedef enum logic [0:0] {
        StIdle,
        StLock
    } state_e;

    state_e         state_q, state_d;
    logic [IDW-1:0] owner_q, owner_d;
    logic [IDW-1:0] last_grant_q, last_grant_d;
    logic [BCW-1:0] beat_cnt_q, beat_cnt_d;

    logic [IDW-1:0] sel;
    logic           sel_vld;
    logic           xfer;

    // Select a requester: rotating priority in IDLE, the lock owner in LOCK.
    always_comb begin
        int  idx;
        logic found;
        sel     = '0;
        sel_vld = 1'b0;
        idx     = 0;
        found   = 1'b0;
        if (state_q == StLock) begin
            sel     = owner_q;
            sel_vld = req_valid[owner_q];
        end else begin
            for (int k = 0; k < int'(NUM_REQ); k++) begin
                idx = int'(last_grant_q) + 1 + k;
                if (idx >= int'(NUM_REQ)) begin
                    idx = idx - int'(NUM_REQ);
                end
                if (!found && req_valid[idx]) begin
                    sel   = IDW'(idx);
                    found = 1'b1;
                end
            end
            sel_vld = |req_valid;
        end
    end

    assign xfer = sel_vld & ~fifo_full & reset_n;

    // Drive the FIFO write side and the per-requester handshake; all quiet in reset.
    always_comb begin
        fifo_wr_en = xfer;
        req_ready  = '0;
        fifo_din   = '0;
        grant_id   = '0;
        busy       = 1'b0;
        if (reset_n) begin
            grant_id = sel;
            busy     = (state_q == StLock);
            for (int i = 0; i < int'(NUM_REQ); i++) begin
                if (sel == IDW'(i)) begin
                    req_ready[i] = xfer;
                    if (sel_vld) begin
                        fifo_din = req_data[i*DATA_WIDTH +: DATA_WIDTH];
                    end
                end
            end
        end
    end

    // Next-state logic for the burst lock, rotation pointer and beat counter.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        beat_cnt_d   = beat_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (xfer) begin
                    last_grant_d = sel;
                    if (MAX_BURST > 1) begin
                        owner_d    = sel;
                        beat_cnt_d = BCW'(1);
                        state_d    = StLock;
                    end
                end
            end
            StLock: begin
                if (!req_valid[owner_q]) begin
                    // Owner went away: release and spend one bubble cycle.
                    state_d    = StIdle;
                    beat_cnt_d = '0;
                end else if (xfer) begin
                    if (beat_cnt_q == LastBeat) begin
                        // last_grant already equals owner, so the next one gets priority.
                        state_d    = StIdle;
                        beat_cnt_d = '0;
                    end else begin
                        beat_cnt_d = beat_cnt_q + BCW'(1);
                    end
                end
            end
            default: begin
                state_d    = StIdle;
                beat_cnt_d = '0;
            end
        endcase
    end

    // State register with synchronous active-low reset; requester 0 wins first after reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            owner_q      <= '0;
            last_grant_q <= IDW'(NUM_REQ - 1);
            beat_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            beat_cnt_q   <= beat_cnt_d;
        end
    end

`ifdef FIFO_ARB_STATS_EN
    logic [15:0] beat_stat_q [NUM_REQ];
    logic [15:0] stall_stat_q;

    // Per-requester accepted-beat counters, saturating at all ones.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(NUM_REQ); i++) begin
                beat_stat_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(NUM_REQ); i++) begin
                if (req_ready[i] && (beat_stat_q[i] != 16'hFFFF)) begin
                    beat_stat_q[i] <= beat_stat_q[i] + 16'd1;
                end
            end
        end
    end

    // Count cycles where a requester is selected but the FIFO is full, saturating.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stall_stat_q <= '0;
        end else if (sel_vld && fifo_full && (stall_stat_q != 16'hFFFF)) begin
            stall_stat_q <= stall_stat_q + 16'd1;
        end
    end

    // Flatten the counter array onto the output vector.
    always_comb begin
        beat_cnt_vec = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            beat_cnt_vec[i*16 +: 16] = beat_stat_q[i];
        end
    end

    assign stall_cnt = stall_stat_q;
`else
    // Statistics disabled: no counters are built.
`endif

    // Never write into a full FIFO, and accept from at most one requester per cycle.
    no_write_when_full: assert property (@(posedge clk) disable iff (!reset_n)
        fifo_full |-> !fifo_wr_en);
    ready_onehot: assert property (@(posedge clk) disable iff (!reset_n)
        $onehot0(req_ready));

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin write-port arbiter that shares one synchronous FIFO write port (wr_en/din/full) between NUM_REQ producers.
- Each producer uses a valid/ready handshake. A winner may hold the port for up to MAX_BURST consecutive beats before the grant rotates.
- Sits directly in front of the team's sync FIFO: fifo_wr_en and fifo_din drive the FIFO write side, and fifo_full is fed back from it.

Parameters:
- NUM_REQ, 4, number of requesters (>=2).
- DATA_WIDTH, 8, data word width; must match the FIFO.
- MAX_BURST, 4, maximum consecutive beats per grant (>=1; 1 means pure per-beat round-robin).
- Localparam IDW = $clog2(NUM_REQ), grant index width.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset_n  input  1  reset, synchronous, active-low.
- req_valid  input  NUM_REQ  bit i = requester i has a word.
- req_data  input  NUM_REQ*DATA_WIDTH  requester i data at bits [i*DATA_WIDTH +: DATA_WIDTH].
- req_ready  output  NUM_REQ  bit i = requester i's word is accepted this cycle.
- fifo_full  input  1  FIFO full flag.
- fifo_wr_en  output  1  FIFO write enable.
- fifo_din  output  DATA_WIDTH  FIFO write data.
- grant_id  output  IDW  index of the selected requester; meaningful only when fifo_wr_en=1.
- busy  output  1  1 while a burst lock is held (state LOCK).

Behaviour:
- State register: state in {IDLE, LOCK}; owner (IDW bits); last_grant (IDW bits); beat_cnt ($clog2(MAX_BURST+1) bits).
- Reset (reset_n=0 at clk edge):
  - state=IDLE, owner=0, last_grant=NUM_REQ-1, beat_cnt=0.
  - While reset_n=0: fifo_wr_en=0, req_ready=0, fifo_din=0, grant_id=0, busy=0.
  - Reset mid-burst drops the lock; after reset, requester 0 has first priority.
- Selection (combinational, from registered state):
  - IDLE: sel is the first i with req_valid[i]=1, searching from (last_grant+1) mod NUM_REQ upward with wrap. sel_vld = |req_valid.
  - LOCK: sel=owner, sel_vld=req_valid[owner].
- Transfer: xfer = sel_vld & ~fifo_full & reset_n.
  - fifo_wr_en = xfer; req_ready = one-hot(sel) when xfer, else 0.
  - fifo_din = req_data slice of sel when sel_vld, else 0; grant_id = sel.
  - Zero latency: the word is written to the FIFO on the same edge the handshake completes.
- IDLE transitions:
  - xfer & MAX_BURST==1: last_grant<=sel; stay IDLE.
  - xfer & MAX_BURST>1: last_grant<=sel, owner<=sel, beat_cnt<=1, state<=LOCK.
  - No xfer (nothing valid, or fifo_full): no state change. No lock is taken while full; arbitration is re-evaluated every cycle.
- LOCK transitions:
  - req_valid[owner]=0: state<=IDLE, beat_cnt<=0, no transfer that cycle (one bubble cycle).
  - xfer & beat_cnt+1==MAX_BURST: state<=IDLE, beat_cnt<=0. last_grant already equals owner, so the next requester gets priority.
  - xfer otherwise: beat_cnt<=beat_cnt+1.
  - fifo_full with owner valid: hold; the lock is kept and beat_cnt is unchanged.
- busy = (state==LOCK).
- Requirements on requesters: once req_valid[i] is asserted it must stay high with stable data until req_ready[i]. The arbiter never drops an accepted word and never writes while fifo_full=1.

Optional Feature:
- Macro FIFO_ARB_STATS_EN.
- Defined:
  - Adds output beat_cnt_vec (NUM_REQ*16 bits); slice i is a 16-bit saturating count (stops at 16'hFFFF) of beats accepted from requester i.
  - Adds output stall_cnt (16 bits, saturating), which increments each cycle sel_vld=1 & fifo_full=1.
  - All counters clear on reset_n=0.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset with all req_valid=1, MAX_BURST=1 -> grants in order 0,1,2,3,0,... one per cycle; fifo_wr_en=1 every cycle; fifo_din matches the granted requester's data.
- MAX_BURST=4, req_valid=4'b0011 held -> req0 gets 4 consecutive beats (busy=1 after the first), then req1 gets 4, repeating.
- In LOCK, owner 2 drops valid after 2 beats -> one cycle with fifo_wr_en=0; state returns to IDLE; the next grant goes to requester 3 if valid.
- fifo_full=1 for 3 cycles mid-burst -> fifo_wr_en=0 and req_ready=0 throughout; owner and beat_cnt held; the burst resumes when full clears with the remaining beats only.
- reset_n=0 for one cycle during a LOCK by requester 1 -> busy=0 afterwards; with all requesters valid, the first grant goes to requester 0.
- FIFO_ARB_STATS_EN defined, 10 beats from req0 plus 5 full-stall cycles -> beat_cnt_vec slice 0 = 10, stall_cnt = 5; a counter preloaded to 16'hFFFF stays at 16'hFFFF.
